// File: rtl/add16_serial_nib_pkg.sv
// rtl/add16_serial_nib_pkg.sv - shared types and sizing for the nibble-serial adder
package add16_serial_nib_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_NIB   = 4;
  localparam int NIBBLES   = DEF_WIDTH / DEF_NIB;
  localparam int IDX_W     = $clog2(NIBBLES);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Index width for a given slice count; a single-slice build still needs a 1-bit index.
  function automatic int idx_bits(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/add16_serial_nib_nibble_add_cin.sv
// rtl/add16_serial_nib_nibble_add_cin.sv - combinational NIB-bit adder slice with carry in/out
module nibble_add_cin #(
  parameter int NIB = 4
) (
  input  logic [NIB-1:0] a,
  input  logic [NIB-1:0] b,
  input  logic           cin,
  output logic [NIB-1:0] sum,
  output logic           cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{NIB{1'b0}}, cin};

endmodule

// File: rtl/add16_serial_nib.sv
// rtl/add16_serial_nib.sv - 16-bit add/sub built from one 4-bit slice reused over four cycles
module add16_serial_nib
  import add16_serial_nib_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NIB   = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic             SUB,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  logic             CIN,
  output logic             READY,
  output logic             DONE,
  output logic [WIDTH-1:0] O,
  output logic             COUT
);

  localparam int NIBS = WIDTH / NIB;
  localparam int IW   = idx_bits(NIBS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBS - 1);

  state_t           state;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] shadow_nxt;
  logic             carry;

  logic [NIB-1:0]   nib_a;
  logic [NIB-1:0]   nib_b;
  logic [NIB-1:0]   nib_s;
  logic             nib_c;

  // Select the active nibble and merge the fresh sum into a copy of the shadow,
  // so the final edge can publish the whole result in one step.
  always_comb begin
    nib_a      = op_a[int'(idx) * NIB +: NIB];
    nib_b      = op_b[int'(idx) * NIB +: NIB];
    shadow_nxt = shadow;
    shadow_nxt[int'(idx) * NIB +: NIB] = nib_s;
  end

  nibble_add_cin #(
    .NIB (NIB)
  ) u_slice (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry),
    .sum  (nib_s),
    .cout (nib_c)
  );

  assign READY = (state == IDLE);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= IDLE;
      idx    <= '0;
      op_a   <= '0;
      op_b   <= '0;
      shadow <= '0;
      carry  <= 1'b0;
      O      <= '0;
      COUT   <= 1'b0;
      DONE   <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            op_a  <= I0;
            // Subtraction is A + ~B + 1; the final carry then reads as "no borrow".
            op_b  <= SUB ? ~I1 : I1;
            carry <= SUB ? 1'b1 : CIN;
            idx   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          shadow <= shadow_nxt;
          carry  <= nib_c;
          idx    <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            O     <= shadow_nxt;
            COUT  <= nib_c;
            DONE  <= 1'b1;
            idx   <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_add16_serial_nib.sv
// tb/tb_add16_serial_nib.sv - self-checking bench for the nibble-serial adder
module tb_add16_serial_nib;

  logic        clk;
  logic        reset;
  logic        start;
  logic        sub;
  logic [15:0] i0;
  logic [15:0] i1;
  logic        cin;
  logic        ready;
  logic        done;
  logic [15:0] o;
  logic        cout;

  int n_checks;
  int n_fail;

  add16_serial_nib #(.WIDTH(16), .NIB(4)) dut (
    .CLK   (clk),
    .RESET (reset),
    .START (start),
    .SUB   (sub),
    .I0    (i0),
    .I1    (i1),
    .CIN   (cin),
    .READY (ready),
    .DONE  (done),
    .O     (o),
    .COUT  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: whole-word arithmetic on 17-bit values.
  function automatic logic [16:0] model(input logic s, input logic [15:0] a, input logic [15:0] b,
                                        input logic c);
    logic [16:0] r;
    if (s) begin
      r[15:0] = a - b;
      r[16]   = (a >= b);
    end else begin
      r = {1'b0, a} + {1'b0, b} + {16'd0, c};
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    i0    = '0;
    i1    = '0;
    cin   = 1'b0;
    step();
    step();
    reset = 1'b0;
    n_checks++;
    if ({ready, done, cout, o} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
      n_fail++;
      $display("FAIL reset_state: ready=%b done=%b cout=%b o=%h, want 1 0 0 0000", ready, done, cout, o);
    end
  endtask

  // Runs one operation from an idle cycle, checking handshake timing and result.
  task automatic run_op(input string name, input logic s, input logic [15:0] a,
                        input logic [15:0] b, input logic c);
    logic [16:0] exp;
    exp = model(s, a, b, c);
    n_checks++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_ready_before: ready=%b want 1", name, ready);
    end
    start = 1'b1; sub = s; i0 = a; i1 = b; cin = c;
    step();
    start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      i0 = 16'($urandom); i1 = 16'($urandom); sub = 1'($urandom); cin = 1'($urandom);
      n_checks++;
      if (ready !== 1'b0 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_busy_t%0d: ready=%b done=%b want 0 0", name, k, ready, done);
      end
      step();
    end
    n_checks++;
    if (done !== 1'b1 || ready !== 1'b1 || o !== exp[15:0] || cout !== exp[16]) begin
      n_fail++;
      $display("FAIL %s_result: done=%b ready=%b o=%h cout=%b want 1 1 %h %b",
               name, done, ready, o, cout, exp[15:0], exp[16]);
    end
    step();
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_done_pulse: done=%b want 0 one cycle after DONE", name, done);
    end
  endtask

  task automatic test_directed();
    run_op("add_plain",  1'b0, 16'h1234, 16'h0FFF, 1'b0);
    run_op("add_wrap",   1'b0, 16'hFFFF, 16'h0001, 1'b0);
    run_op("add_cin",    1'b0, 16'hFFFF, 16'h0000, 1'b1);
    run_op("sub_nobor",  1'b1, 16'h1000, 16'h0001, 1'b1);
    run_op("sub_borrow", 1'b1, 16'h0000, 16'h0001, 1'b0);
    run_op("sub_equal",  1'b1, 16'hA5A5, 16'hA5A5, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++)
      run_op("rand", 1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
  endtask

  // START held high throughout; operands churn while busy and only the
  // values present on each accepting edge may affect results.
  task automatic test_back_to_back();
    logic [16:0] expq[$];
    logic [16:0] exp;
    logic        ns;
    logic [15:0] na, nb;
    logic        nc;
    ns = 1'($urandom); na = 16'($urandom); nb = 16'($urandom); nc = 1'($urandom);
    start = 1'b1; sub = ns; i0 = na; i1 = nb; cin = nc;
    expq.push_back(model(ns, na, nb, nc));
    step();
    for (int op = 0; op < 6; op++) begin
      for (int k = 1; k <= 4; k++) begin
        i0 = 16'($urandom); i1 = 16'($urandom); sub = 1'($urandom); cin = 1'($urandom);
        n_checks++;
        if (ready !== 1'b0 || done !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_busy op%0d t%0d: ready=%b done=%b want 0 0", op, k, ready, done);
        end
        step();
      end
      exp = expq.pop_front();
      n_checks++;
      if (done !== 1'b1 || ready !== 1'b1 || o !== exp[15:0] || cout !== exp[16]) begin
        n_fail++;
        $display("FAIL b2b_result op%0d: done=%b ready=%b o=%h cout=%b want 1 1 %h %b",
                 op, done, ready, o, cout, exp[15:0], exp[16]);
      end
      if (op < 5) begin
        ns = 1'($urandom); na = 16'($urandom); nb = 16'($urandom); nc = 1'($urandom);
        sub = ns; i0 = na; i1 = nb; cin = nc;
        expq.push_back(model(ns, na, nb, nc));
      end else begin
        start = 1'b0;
      end
      step();
    end
  endtask

  task automatic test_reset_midop();
    logic seen;
    start = 1'b1; sub = 1'b0; i0 = 16'h1234; i1 = 16'h4321; cin = 1'b1;
    step();
    start = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++;
    if ({ready, done, cout, o} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
      n_fail++;
      $display("FAIL midop_reset_state: ready=%b done=%b cout=%b o=%h want 1 0 0 0000", ready, done, cout, o);
    end
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (done === 1'b1) seen = 1'b1;
      step();
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL midop_no_done: done seen=%b want 0", seen);
    end
    // RESET and START together: START must be dropped.
    reset = 1'b1; start = 1'b1; i0 = 16'h0F0F; i1 = 16'h0101;
    step();
    reset = 1'b0; start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (done === 1'b1 || ready !== 1'b1) seen = 1'b1;
      step();
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_start_same_cycle: activity seen=%b want 0", seen);
    end
  endtask

  task automatic test_hold();
    logic [16:0] exp;
    exp = model(1'b0, 16'h8001, 16'h8002, 1'b1);
    run_op("hold_setup", 1'b0, 16'h8001, 16'h8002, 1'b1);
    for (int k = 0; k < 20; k++) begin
      i0 = 16'($urandom); i1 = 16'($urandom); sub = 1'($urandom); cin = 1'($urandom);
      n_checks++;
      if (o !== exp[15:0] || cout !== exp[16] || done !== 1'b0 || ready !== 1'b1) begin
        n_fail++;
        $display("FAIL hold_c%0d: o=%h cout=%b done=%b ready=%b want %h %b 0 1",
                 k, o, cout, done, ready, exp[15:0], exp[16]);
      end
      step();
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_midop();
    test_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
